// File: rtl/sysid_regs_avmm.sv
`default_nettype none
// ============================================================================
// Module  : sysid_regs_avmm
// Brief   : Avalon-MM system-identification register block with build ID,
//           timestamp, scratch, capabilities, optional uptime counter
//           (SYSID_UPTIME_EN) and read-only user status channels.
// Revision: 1.0 - initial release
// ============================================================================
module sysid_regs_avmm #(
  parameter logic [31:0] ID_VALUE     = 32'h0000_0001,
  parameter logic [31:0] TIMESTAMP    = 32'h0000_0000,
  parameter int          NUM_USER     = 2,
  parameter int          READ_LATENCY = 1,
  parameter int          CLK_FREQ_HZ  = 50000000
) (
  input  logic                                    clock,
  input  logic                                    reset_n,
  input  logic [3:0]                              address,
  input  logic                                    read,
  input  logic                                    write,
  input  logic [31:0]                             writedata,
  input  logic [3:0]                              byteenable,
  input  logic [((NUM_USER > 0) ? NUM_USER : 1)*32-1:0] user_status,
  output logic [31:0]                             readdata,
  output logic                                    readdatavalid
);

  localparam logic [3:0] c_ADDR_ID      = 4'd0;
  localparam logic [3:0] c_ADDR_TS      = 4'd1;
  localparam logic [3:0] c_ADDR_SCRATCH = 4'd2;
  localparam logic [3:0] c_ADDR_UPTIME  = 4'd3;
  localparam logic [3:0] c_ADDR_CAPS    = 4'd4;

`ifdef SYSID_UPTIME_EN
  localparam logic c_UPTIME_PRESENT = 1'b1;
`else
  localparam logic c_UPTIME_PRESENT = 1'b0;
`endif

  localparam logic [31:0] c_CAPS = {22'd0, 2'(READ_LATENCY), 4'(NUM_USER),
                                    3'd0, c_UPTIME_PRESENT};

  logic [31:0] r_scratch;
  logic [31:0] w_uptime;
  logic [31:0] w_rd_data;
  logic        w_wr_scratch;

  assign w_wr_scratch = write && (address == c_ADDR_SCRATCH);

  // Scratch word, byte-lane qualified
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_scratch <= '0;
    end else if (w_wr_scratch) begin
      for (int b = 0; b < 4; b++) begin
        if (byteenable[b]) begin
          r_scratch[8*b +: 8] <= writedata[8*b +: 8];
        end
      end
    end
  end

`ifdef SYSID_UPTIME_EN
  localparam int c_PRESC_W = (CLK_FREQ_HZ > 1) ? $clog2(CLK_FREQ_HZ) : 1;
  localparam logic [c_PRESC_W-1:0] c_PRESC_TC = c_PRESC_W'(CLK_FREQ_HZ - 1);

  logic [c_PRESC_W-1:0] r_presc;
  logic [31:0]          r_uptime;
  logic                 w_wr_uptime;
  logic                 w_presc_tc;

  assign w_wr_uptime = write && (address == c_ADDR_UPTIME);
  assign w_presc_tc  = (r_presc == c_PRESC_TC);

  // A software clear takes priority over a coincident terminal count
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_presc  <= '0;
      r_uptime <= '0;
    end else if (w_wr_uptime) begin
      r_presc  <= '0;
      r_uptime <= '0;
    end else if (w_presc_tc) begin
      r_presc <= '0;
      if (r_uptime != 32'hFFFF_FFFF) begin
        r_uptime <= r_uptime + 32'd1;
      end
    end else begin
      r_presc <= r_presc + c_PRESC_W'(1);
    end
  end

  assign w_uptime = r_uptime;
`else
  assign w_uptime = 32'd0;
`endif

  // Read mux reflects pre-write state and live user_status at acceptance
  always_comb begin
    w_rd_data = 32'd0;
    case (address)
      c_ADDR_ID:      w_rd_data = ID_VALUE;
      c_ADDR_TS:      w_rd_data = TIMESTAMP;
      c_ADDR_SCRATCH: w_rd_data = r_scratch;
      c_ADDR_UPTIME:  w_rd_data = w_uptime;
      c_ADDR_CAPS:    w_rd_data = c_CAPS;
      default:        w_rd_data = 32'd0;
    endcase
    for (int i = 0; i < NUM_USER; i++) begin
      if (address == 4'(8 + i)) begin
        w_rd_data = user_status[32*i +: 32];
      end
    end
  end

  logic [31:0] r_pipe_data [READ_LATENCY];
  logic        r_pipe_vld  [READ_LATENCY];

  // Data in each stage only moves with a valid token, so the last stage
  // holds the most recently returned word between pulses.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      for (int k = 0; k < READ_LATENCY; k++) begin
        r_pipe_vld[k]  <= 1'b0;
        r_pipe_data[k] <= '0;
      end
    end else begin
      r_pipe_vld[0] <= read;
      if (read) begin
        r_pipe_data[0] <= w_rd_data;
      end
      for (int k = 1; k < READ_LATENCY; k++) begin
        r_pipe_vld[k] <= r_pipe_vld[k-1];
        if (r_pipe_vld[k-1]) begin
          r_pipe_data[k] <= r_pipe_data[k-1];
        end
      end
    end
  end

  assign readdata      = r_pipe_data[READ_LATENCY-1];
  assign readdatavalid = r_pipe_vld[READ_LATENCY-1];

endmodule
`default_nettype wire

// File: doc/sysid_regs_avmm.md
# sysid_regs_avmm

Parametrised Avalon-MM system-identification register block; successor to the single-word sysid slave. Exposes a build ID, build timestamp, a writable scratch word, a capabilities word, an optional uptime-seconds counter and NUM_USER read-only status channels. Reads are pipelined with a fixed READ_LATENCY. Sits on the Qsys control bus next to the CPU data master for software identification and board bring-up.

## Interface
- ID_VALUE, 32'h0000_0001: value returned at word 0.
- TIMESTAMP, 32'h0000_0000: build time (Unix seconds) returned at word 1.
- NUM_USER, 2: status channels, range 0..8.
- READ_LATENCY, 1: cycles from read acceptance to readdatavalid, range 1..3.
- CLK_FREQ_HZ, 50000000: clock cycles per uptime second, minimum 2.

- clock  in  1  system clock; all logic on rising edge.
- reset_n  in  1  asynchronous active-low reset; deassertion synchronised externally.
- address  in  4  word address.
- read  in  1  read request, accepted every asserted cycle.
- write  in  1  write request, accepted every asserted cycle.
- writedata  in  32  write data.
- byteenable  in  4  byte lanes for writes.
- user_status  in  max(NUM_USER,1)*32  channel i on bits [32i+31:32i].
- readdata  out  32  read data, valid only with readdatavalid.
- readdatavalid  out  1  one pulse per accepted read.

## Operation
- Word map: 0 ID_VALUE (RO); 1 TIMESTAMP (RO); 2 SCRATCH (RW, byteenable-qualified); 3 UPTIME (RO; any write clears it); 4 CAPS (RO); 8+i user_status channel i for i < NUM_USER (RO). All other addresses read 0. Writes to RO words are ignored.
- CAPS: bit0 = uptime present; bits[7:4] = NUM_USER; bits[9:8] = READ_LATENCY; other bits 0.
- No waitrequest. Back-to-back reads are allowed every cycle. The read pipeline is READ_LATENCY stages deep and is fully pipelined.
- Read data is sampled in the acceptance cycle. user_status is captured at acceptance, not at return.
- Read and write in the same cycle are both performed. The read returns the pre-write value.
- Uptime: the prescaler counts 0..CLK_FREQ_HZ-1. On terminal count, the prescaler wraps to 0 and UPTIME increments. UPTIME saturates at 32'hFFFF_FFFF.
- A write to word 3 clears UPTIME and the prescaler in the next cycle. If the write coincides with a terminal count, the clear wins and UPTIME reads 0.

## Timing
- Reset values: readdata 0, readdatavalid 0, SCRATCH 0, UPTIME 0, prescaler 0, read pipeline empty.
- Read accepted at cycle N: readdatavalid=1 and readdata valid at cycle N+READ_LATENCY, for exactly one cycle per read.
- readdata holds its last value when readdatavalid=0.
- A write takes effect at the next edge. A read accepted in the following cycle sees the new value.
- Reset asserted mid-operation discards all in-flight reads; no readdatavalid follows. Registers return to reset values asynchronously.

## Configuration
- SYSID_UPTIME_EN defined: the prescaler and UPTIME counter are built. CAPS bit0 = 1.
- SYSID_UPTIME_EN undefined: no counter logic is built. Word 3 reads 0, writes to word 3 are ignored, and CAPS bit0 = 0.

## Test plan
- Reset, then read words 0, 1 and 4 with ID_VALUE=32'h1234_5678, NUM_USER=2, READ_LATENCY=2 -> 32'h1234_5678, TIMESTAMP, and 32'h0000_0221 (macro on), each arriving 2 cycles after its read.
- Four back-to-back reads of words 0,1,2,15 with READ_LATENCY=3 -> four consecutive readdatavalid pulses starting 3 cycles after the first read, in order, with word 15 = 0.
- Write SCRATCH 32'hAABBCCDD with byteenable=4'b0101 after reset -> reads 32'h00BB00DD. In the same cycle, read word 2 with write 32'hFFFF_FFFF -> old value returned; the next read returns the new value.
- CLK_FREQ_HZ=10, macro on: after 35 cycles UPTIME=3. Write word 3 on the terminal-count cycle -> UPTIME=0, and it increments to 1 ten cycles later.
- Drive user_status channel 1 = 32'hCAFE_0001, read word 9, change the input to 32'h0 the next cycle -> returned data is 32'hCAFE_0001.
- Assert reset_n low one cycle after a read with READ_LATENCY=3 -> no readdatavalid appears. With the macro off, word 3 reads 0 and CAPS bit0 = 0.
